// File: rtl/divisor_freq_param.sv
// Programmable clock-enable divider: CLK_1/TICK fire on each terminal count of cnt against div_q.
// Outputs registered (one edge after the terminal compare); no backpressure, ratio changes land on period boundaries.
module divisor_freq_param #(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             CLK_50,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIV,
  input  logic             DIV_LOAD,
  input  logic             MODE,
  input  logic             RUN,
  input  logic             STEP,
  output logic             CLK_1,
  output logic             TICK,
  output logic             PEND
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] div_p_q, div_p_d;
  logic             pend_q, pend_d;
  logic             mode_q, mode_d;
  logic             step_q, step_d;
  logic             clk1_q, clk1_d;
  logic             tick_q, tick_d;
  logic             step_rise;
  logic             term;

  // STEP is only honoured while halted; its history is tracked regardless.
  assign step_rise = ~RUN & STEP & ~step_q;
  assign term      = (RUN & (cnt_q == div_q)) | step_rise;

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    div_p_d = div_p_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    step_d  = STEP;
    clk1_d  = clk1_q;
    tick_d  = 1'b0;

    if (term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      mode_d = MODE;
      clk1_d = MODE ? ~clk1_q : 1'b1;
      if (pend_q) begin
        div_d  = div_p_q;
        pend_d = 1'b0;
      end
    end else begin
      if (RUN) begin
        cnt_d = cnt_q + ONE;
      end
      if (!mode_q) begin
        clk1_d = 1'b0;
      end
    end

    // A load either takes effect now (halted, or coinciding with a terminal event) or waits as pending.
    if (DIV_LOAD) begin
      div_p_d = DIV;
      if (!RUN) begin
        div_d  = DIV;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (term) begin
        div_d  = DIV;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      div_q   <= DEF_DIV;
      div_p_q <= '0;
      pend_q  <= 1'b0;
      mode_q  <= 1'b0;
      step_q  <= 1'b0;
      clk1_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      div_p_q <= div_p_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      clk1_q  <= clk1_d;
      tick_q  <= tick_d;
    end
  end

  assign CLK_1 = clk1_q;
  assign TICK  = tick_q;
  assign PEND  = pend_q;

endmodule

// File: tb/tb_divisor_freq_param.sv
// Directed bench for divisor_freq_param: stimulus queues expected {CLK_1,TICK,PEND}, a monitor pops and compares.
module tb_divisor_freq_param;

  localparam int WIDTH = 26;

  logic             clk_50 = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] div = '0;
  logic             div_load = 1'b0;
  logic             mode = 1'b0;
  logic             run = 1'b0;
  logic             step = 1'b0;
  logic             clk_1;
  logic             tick;
  logic             pend;

  int total = 0;
  int bad = 0;

  string      q_nm[$];
  logic [2:0] q_exp[$];
  event       mon_ev;

  divisor_freq_param #(.WIDTH(WIDTH), .DEFAULT_DIV(1)) dut (
    .CLK_50(clk_50),
    .RST(rst),
    .DIV(div),
    .DIV_LOAD(div_load),
    .MODE(mode),
    .RUN(run),
    .STEP(step),
    .CLK_1(clk_1),
    .TICK(tick),
    .PEND(pend)
  );

  always #5 clk_50 = ~clk_50;

  // Monitor: one expected entry is consumed per sample point.
  initial begin : monitor
    string      nm;
    logic [2:0] exp_v;
    forever begin
      @(negedge clk_50 or mon_ev);
      if (q_exp.size() > 0) begin
        nm    = q_nm.pop_front();
        exp_v = q_exp.pop_front();
        total++;
        if ({clk_1, tick, pend} !== exp_v) begin
          bad++;
          $display("FAIL %s: clk1/tick/pend got %b%b%b expected %b", nm, clk_1, tick, pend, exp_v);
        end
      end
    end
  end

  task automatic expect_now(input string nm, input logic e_clk, input logic e_tick, input logic e_pend);
    q_nm.push_back(nm);
    q_exp.push_back({e_clk, e_tick, e_pend});
    -> mon_ev;
  endtask

  task automatic edge_chk(input string nm, input logic e_clk, input logic e_tick, input logic e_pend);
    q_nm.push_back(nm);
    q_exp.push_back({e_clk, e_tick, e_pend});
    @(posedge clk_50);
    #1;
    div_load = 1'b0;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    div      = v;
    div_load = 1'b1;
  endtask

  initial begin : stim
    logic tk;
    #1 rst = 1'b1;
    #1 expect_now("reset_state", 1'b0, 1'b0, 1'b0);
    run  = 1'b1;
    mode = 1'b0;
    @(negedge clk_50);
    #1 rst = 1'b0;

    // Default ratio 1: pulse high on every second edge.
    for (int e = 1; e <= 6; e++) edge_chk("p1_default", e % 2 == 0, e % 2 == 0, 1'b0);

    // Ratio 9 via pending load, then 4 loaded mid-period.
    load(9);
    edge_chk("p2_load9", 1'b0, 1'b0, 1'b1);
    edge_chk("p2_apply9", 1'b1, 1'b1, 1'b0);
    for (int e = 9; e <= 28; e++) begin
      if (e == 10) load(4);
      tk = (e == 18) || (e == 23) || (e == 28);
      edge_chk("p2_div9_to_4", tk, tk, (e >= 10) && (e <= 17));
    end

    // Square mode, ratio 2: 3 high / 3 low.
    mode = 1'b1;
    for (int e = 29; e <= 44; e++) begin
      if (e == 29) load(2);
      if (e < 33) edge_chk("p3_sq_pending", 1'b0, 1'b0, 1'b1);
      else edge_chk("p3_sq_div2", ((e - 33) / 3) % 2 == 0, (e - 33) % 3 == 0, 1'b0);
    end

    // Ratio 0 loaded on a terminal edge: toggle every cycle.
    for (int e = 45; e <= 50; e++) begin
      if (e == 45) load(0);
      edge_chk("p3_sq_div0", (e - 45) % 2 == 0, 1'b1, 1'b0);
    end

    // Ratio 9 on a terminal edge, then halt with cnt=3.
    load(9);
    edge_chk("p4_load9", 1'b1, 1'b1, 1'b0);
    for (int e = 52; e <= 54; e++) edge_chk("p4_count", 1'b1, 1'b0, 1'b0);
    run = 1'b0;
    edge_chk("p4_halt", 1'b1, 1'b0, 1'b0);

    // Three STEP pulses of 4 cycles, last one held high.
    for (int e = 56; e <= 79; e++) begin
      step = (e >= 72) || ((e - 56) % 8 < 4);
      tk = (e == 56) || (e == 64) || (e == 72);
      edge_chk("p4_step", (e >= 64) && (e < 72), tk, 1'b0);
    end

    // Resume from cnt=0; STEP while running is ignored.
    run = 1'b1;
    for (int e = 80; e <= 89; e++) begin
      step = (e == 83);
      edge_chk("p4_resume", e == 89, e == 89, 1'b0);
    end
    step = 1'b0;

    // Pending load outstanding when reset hits mid-period.
    edge_chk("p5_run", 1'b1, 1'b0, 1'b0);
    load(5);
    edge_chk("p5_pend", 1'b1, 1'b0, 1'b1);
    @(negedge clk_50);
    #1 rst = 1'b1;
    mode = 1'b0;
    #1 expect_now("p5_rst_async", 1'b0, 1'b0, 1'b0);
    edge_chk("p5_rst_hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk_50);
    #1 rst = 1'b0;
    for (int r = 1; r <= 4; r++) edge_chk("p5_after_rst", r % 2 == 0, r % 2 == 0, 1'b0);

    // Load 7 on the terminal edge: next period 8 cycles, PEND stays low.
    edge_chk("p6_pre", 1'b0, 1'b0, 1'b0);
    load(7);
    edge_chk("p6_load_on_term", 1'b1, 1'b1, 1'b0);
    for (int r = 7; r <= 15; r++) edge_chk("p6_div7", r == 14, r == 14, 1'b0);

    @(negedge clk_50);
    #1;
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
